hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Hazard and forwarding unit for the 5-stage MIPS pipeline, directly downstream of the decode-stage controller.
- Consumes the decoded instruction's register reads and their Tuse, plus its write address and Tnew.
- Keeps a per-stage scoreboard (E, M, W) of destination register and decaying Tnew.
- Produces the stall for PC / IF-ID / ID-EX and the forwarding selects for D-stage and E-stage operands.

Parameters:
- REG_AW, 5, register address width
- TW, 2, Tuse/Tnew width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_d  in  5  D-stage rs index
- rt_d  in  5  D-stage rt index
- rs_tuse_d  in  2  rs Tuse; 3 = not read
- rt_tuse_d  in  2  rt Tuse; 3 = not read
- wa_d  in  5  D-stage destination register; 0 = no write
- tnew_d  in  2  D-stage Tnew, relative to E entry
- flush_e  in  1  force a bubble into E next cycle (exception/redirect)
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
- fwd_rs_d  out  2  D-stage rs source: 0 RF, 1 E, 2 M, 3 W
- fwd_rt_d  out  2  same encoding for rt
- fwd_rs_e  out  2  E-stage rs source: 0 ID/EX value, 2 M, 3 W
- fwd_rt_e  out  2  same encoding for rt

Behaviour:
- Reset is asynchronous. All stage entries are cleared: wa=0, tnew=0, rs/rt=0. Outputs then read stall=0 and all fwd=0.
- State per stage X∈{E,M,W}: wa_X, tnew_X. E additionally holds rs_e and rt_e.
- Every rising edge:
  - W <= M with tnew saturating-decremented (floor 0).
  - M <= E with tnew saturating-decremented.
  - E <= D fields, or a bubble (wa=0, tnew=0, rs=rt=0) when stall=1 or flush_e=1.
  - No enable input; the scoreboard always advances.
- Match definition: match_X(r) = (r != 0) && (wa_X == r).
  - Register 0 never matches, never stalls, never forwards.
- Nearest match wins, priority E > M > W. Older stages are ignored once a younger stage matches.
- Stall, combinational: stall = hz(rs_d, rs_tuse_d) | hz(rt_d, rt_tuse_d).
  - hz(r, tuse) = 1 iff the nearest matching stage X has tnew_X > tuse.
  - Tuse=3 never stalls, because tnew ≤ 2.
- D forward select, combinational: nearest matching stage X with tnew_X == 0 gives the code for X. Otherwise 0.
  - A match with 0 < tnew ≤ tuse returns 0; the operand is resolved later by the E select.
- E forward select, combinational, uses rs_e / rt_e against M then W only. Select M if tnew_M == 0, else W if tnew_W == 0, else 0.
- Stall and flush_e in the same cycle: a single bubble is inserted; no double effect.
- stall must not depend on its own registered value; there is no combinational loop through fwd.
- Reset asserted mid-stall: all entries clear immediately; stall drops asynchronously with rst_n low.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With the macro defined:
  - Adds output stall_cnt (32 bits), reset to 0.
  - Increments on every cycle with stall=1; wraps at 2^32-1 to 0.
  - Adds output stall_rs_only (1 bit): stall caused by rs alone.
- Without the macro: neither port nor the counter logic exists.

Decomposition:
- Package mips_hazard_pkg holds:
  - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3
  - TUSE_NONE=3
  - a stage-entry struct {wa, tnew}
- One natural sub-module: hazard_stage_reg, a single scoreboard slot with saturating tnew decrement and bubble-load. It is instantiated three times; E adds the rs/rt fields.

Test Plan:
- lw $2 (wa=2, tnew=2) then addu rs=2 tuse=1:
  - stall=1 for exactly 1 cycle.
  - Next cycle stall=0, fwd_rs_d=0.
  - The following cycle fwd_rs_e=3 (W).
- addu $3 (tnew=1) then beq rs=3 tuse=0: stall 1 cycle, then fwd_rs_d=2 (M).
- ori $4 (tnew=1), nop, then sw rt=4 tuse=2: no stall; fwd_rt_d=2.
- Two in-flight writers to $5 (E tnew=1, M tnew=0), then reader tuse=1: nearest (E) governs.
  - No stall; fwd_rs_d=0.
  - Next cycle fwd_rs_e=2.
- Writer wa=0 with tnew=2, then reader rs=0 tuse=0: stall=0, fwd=0.
- Stall caused by lw, rst_n pulsed low mid-stall: stall=0 and all fwd=0 asynchronously. With HAZARD_STATS_EN, stall_cnt=0 afterwards.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared encodings for the hazard scoreboard: forward-select codes, the "operand not read" Tuse,
// the scoreboard slot type and the saturating Tnew decrement used as an entry moves down the pipe.
package mips_hazard_pkg;

  localparam int SB_AW = 5;
  localparam int SB_TW = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [SB_TW-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [SB_AW-1:0] wa;
    logic [SB_TW-1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{wa: '0, tnew: '0};

  function automatic logic [SB_TW-1:0] tnew_dec(input logic [SB_TW-1:0] t);
    return (t == '0) ? '0 : t - SB_TW'(1);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One scoreboard slot {wa, tnew}; 1-cycle load, optional saturating Tnew decrement on load.
// No backpressure: loads every cycle, a bubble load clears the slot.
module hazard_stage_reg
  import mips_hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble,
  input  logic             dec,
  input  logic [SB_AW-1:0] d_wa,
  input  logic [SB_TW-1:0] d_tnew,
  output logic [SB_AW-1:0] q_wa,
  output logic [SB_TW-1:0] q_tnew
);

  stage_t q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= STAGE_BUBBLE;
    end else if (bubble) begin
      q <= STAGE_BUBBLE;
    end else begin
      q <= '{wa: d_wa, tnew: (dec ? tnew_dec(d_tnew) : d_tnew)};
    end
  end

  assign q_wa   = q.wa;
  assign q_tnew = q.tnew;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: combinational stall and D/E forward selects from an E/M/W scoreboard; state advances every cycle.
// No backpressure input; stall freezes PC/IF-ID and bubbles E. HAZARD_STATS_EN adds stall_cnt and stall_rs_only.
module hazard_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TW-1:0]     rs_tuse_d,
  input  logic [TW-1:0]     rt_tuse_d,
  input  logic [REG_AW-1:0] wa_d,
  input  logic [TW-1:0]     tnew_d,
  input  logic              flush_e,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic              stall_rs_only
`endif
);

  logic [REG_AW-1:0] wa_e, wa_m, wa_w;
  logic [TW-1:0]     tnew_e, tnew_m, tnew_w;
  logic [REG_AW-1:0] rs_e, rt_e;
  logic              bubble_e;

  logic [1:0]        src_rs, src_rt;
  logic [TW-1:0]     tn_rs, tn_rt;
  logic              hz_rs, hz_rt;

  // Stall and flush collapse into one bubble; Tnew is relative to E entry, so E loads it undecremented.
  assign bubble_e = stall | flush_e;

  hazard_stage_reg u_stage_e (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (bubble_e),
    .dec    (1'b0),
    .d_wa   (wa_d),
    .d_tnew (tnew_d),
    .q_wa   (wa_e),
    .q_tnew (tnew_e)
  );

  hazard_stage_reg u_stage_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .dec    (1'b1),
    .d_wa   (wa_e),
    .d_tnew (tnew_e),
    .q_wa   (wa_m),
    .q_tnew (tnew_m)
  );

  hazard_stage_reg u_stage_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .dec    (1'b1),
    .d_wa   (wa_m),
    .d_tnew (tnew_m),
    .q_wa   (wa_w),
    .q_tnew (tnew_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_e <= '0;
      rt_e <= '0;
    end else if (bubble_e) begin
      rs_e <= '0;
      rt_e <= '0;
    end else begin
      rs_e <= rs_d;
      rt_e <= rt_d;
    end
  end

  function automatic logic [1:0] near_src(input logic [REG_AW-1:0] r,
                                          input logic [REG_AW-1:0] we,
                                          input logic [REG_AW-1:0] wm,
                                          input logic [REG_AW-1:0] ww);
    if (r == '0) return FWD_RF;
    if (we == r) return FWD_E;
    if (wm == r) return FWD_M;
    if (ww == r) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [TW-1:0] src_tnew(input logic [1:0]    src,
                                             input logic [TW-1:0] t_e,
                                             input logic [TW-1:0] t_m,
                                             input logic [TW-1:0] t_w);
    case (src)
      FWD_E:   return t_e;
      FWD_M:   return t_m;
      FWD_W:   return t_w;
      default: return '0;
    endcase
  endfunction

  // The E operand only looks at M and W; a matching M with pending data hides an older W.
  function automatic logic [1:0] e_src(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] wm,
                                       input logic [TW-1:0]     t_m,
                                       input logic [REG_AW-1:0] ww,
                                       input logic [TW-1:0]     t_w);
    if (r == '0) return FWD_RF;
    if (wm == r) return (t_m == '0) ? FWD_M : FWD_RF;
    if (ww == r) return (t_w == '0) ? FWD_W : FWD_RF;
    return FWD_RF;
  endfunction

  always_comb begin
    src_rs = near_src(rs_d, wa_e, wa_m, wa_w);
    src_rt = near_src(rt_d, wa_e, wa_m, wa_w);
    tn_rs  = src_tnew(src_rs, tnew_e, tnew_m, tnew_w);
    tn_rt  = src_tnew(src_rt, tnew_e, tnew_m, tnew_w);

    hz_rs  = (src_rs != FWD_RF) && (rs_tuse_d != TUSE_NONE) && (tn_rs > rs_tuse_d);
    hz_rt  = (src_rt != FWD_RF) && (rt_tuse_d != TUSE_NONE) && (tn_rt > rt_tuse_d);
    stall  = hz_rs | hz_rt;

    fwd_rs_d = ((src_rs != FWD_RF) && (tn_rs == '0)) ? src_rs : FWD_RF;
    fwd_rt_d = ((src_rt != FWD_RF) && (tn_rt == '0)) ? src_rt : FWD_RF;
    fwd_rs_e = e_src(rs_e, wa_m, tnew_m, wa_w, tnew_w);
    fwd_rt_e = e_src(rt_e, wa_m, tnew_m, wa_w, tnew_w);
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_rs_only = hz_rs & ~hz_rt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic against an
// age-indexed model of in-flight instructions (remaining Tnew = entry Tnew minus age, floored).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_d, rt_d, wa_d;
  logic [1:0]  rs_tuse_d, rt_tuse_d, tnew_d;
  logic        flush_e;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic        stall_rs_only;
`endif

  hazard_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .rs_tuse_d (rs_tuse_d),
    .rt_tuse_d (rt_tuse_d),
    .wa_d      (wa_d),
    .tnew_d    (tnew_d),
    .flush_e   (flush_e),
    .stall     (stall),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .stall_rs_only (stall_rs_only)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: index = age in cycles since E entry (0=E, 1=M, 2=W).
  int          m_wa[3];
  int          m_t0[3];
  int          m_rs_e, m_rt_e;
  logic [31:0] m_cnt;

  function automatic int rem(int i);
    return (m_t0[i] > i) ? m_t0[i] - i : 0;
  endfunction

  function automatic int near(int r);
    if (r == 0) return -1;
    for (int i = 0; i < 3; i++) if (m_wa[i] == r) return i;
    return -1;
  endfunction

  function automatic bit m_hz(int r, int tuse);
    int i = near(r);
    return (i >= 0) && (rem(i) > tuse);
  endfunction

  function automatic int m_fwd_d(int r);
    int i = near(r);
    if (i >= 0 && rem(i) == 0) return i + 1;
    return 0;
  endfunction

  function automatic int m_fwd_e(int r);
    if (r == 0) return 0;
    for (int i = 1; i < 3; i++) if (m_wa[i] == r) return (rem(i) == 0) ? i + 1 : 0;
    return 0;
  endfunction

  function automatic bit m_stall();
    return m_hz(int'(rs_d), int'(rs_tuse_d)) | m_hz(int'(rt_d), int'(rt_tuse_d));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_wa[i] = 0;
      m_t0[i] = 0;
    end
    m_rs_e = 0;
    m_rt_e = 0;
    m_cnt  = '0;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tus,
                       input logic [1:0] tut, input logic [4:0] wa, input logic [1:0] tn,
                       input logic fl);
    @(negedge clk);
    rs_d = rs; rt_d = rt; rs_tuse_d = tus; rt_tuse_d = tut;
    wa_d = wa; tnew_d = tn; flush_e = fl;
    #1;
  endtask

  task automatic advance();
    bit b;
    b = m_stall() | flush_e;
    if (m_stall()) m_cnt = m_cnt + 32'd1;
    @(posedge clk);
    for (int i = 2; i > 0; i--) begin
      m_wa[i] = m_wa[i-1];
      m_t0[i] = m_t0[i-1];
    end
    if (b) begin
      m_wa[0] = 0; m_t0[0] = 0; m_rs_e = 0; m_rt_e = 0;
    end else begin
      m_wa[0] = int'(wa_d); m_t0[0] = int'(tnew_d);
      m_rs_e = int'(rs_d);  m_rt_e = int'(rt_d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 3, 3, 0, 0, 0);
      advance();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rs_d = 5'd1; rt_d = 5'd2; rs_tuse_d = 2'd0; rt_tuse_d = 2'd0;
    wa_d = 5'd1; tnew_d = 2'd2; flush_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 9'd0)
      $display("FAIL reset_outputs: got stall=%b fwd=%0d/%0d/%0d/%0d, expected all 0",
               stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e);
    else n_pass++;
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_load_use();
    idle(3);
    drive(0, 0, 3, 3, 2, 2, 0); advance();
    drive(2, 0, 1, 3, 9, 1, 0);
    n_checks++;
    if (stall !== 1'b1) $display("FAIL lw_use_stall: got %b expected 1", stall); else n_pass++;
    advance();
    drive(2, 0, 1, 3, 9, 1, 0);
    n_checks++;
    if (stall !== 1'b0) $display("FAIL lw_use_release: got %b expected 0", stall); else n_pass++;
    n_checks++;
    if (fwd_rs_d !== 2'd0) $display("FAIL lw_use_fwd_d: got %0d expected 0", fwd_rs_d); else n_pass++;
    advance();
    drive(0, 0, 3, 3, 0, 0, 0);
    n_checks++;
    if (fwd_rs_e !== 2'd3) $display("FAIL lw_use_fwd_e: got %0d expected 3", fwd_rs_e); else n_pass++;
    advance();
  endtask

  task automatic test_branch();
    idle(3);
    drive(0, 0, 3, 3, 3, 1, 0); advance();
    drive(3, 0, 0, 3, 0, 0, 0);
    n_checks++;
    if (stall !== 1'b1) $display("FAIL branch_stall: got %b expected 1", stall); else n_pass++;
    advance();
    drive(3, 0, 0, 3, 0, 0, 0);
    n_checks++;
    if (stall !== 1'b0) $display("FAIL branch_release: got %b expected 0", stall); else n_pass++;
    n_checks++;
    if (fwd_rs_d !== 2'd2) $display("FAIL branch_fwd_d: got %0d expected 2", fwd_rs_d); else n_pass++;
    advance();
  endtask

  task automatic test_store_data();
    idle(3);
    drive(0, 0, 3, 3, 4, 1, 0); advance();
    idle(1);
    drive(0, 4, 3, 2, 0, 0, 0);
    n_checks++;
    if (stall !== 1'b0) $display("FAIL store_stall: got %b expected 0", stall); else n_pass++;
    n_checks++;
    if (fwd_rt_d !== 2'd2) $display("FAIL store_fwd_rt_d: got %0d expected 2", fwd_rt_d); else n_pass++;
    advance();
  endtask

  task automatic test_nearest_wins();
    idle(3);
    drive(0, 0, 3, 3, 5, 1, 0); advance();
    drive(0, 0, 3, 3, 5, 1, 0); advance();
    drive(5, 0, 1, 3, 0, 0, 0);
    n_checks++;
    if (stall !== 1'b0) $display("FAIL nearest_stall: got %b expected 0", stall); else n_pass++;
    n_checks++;
    if (fwd_rs_d !== 2'd0) $display("FAIL nearest_fwd_d: got %0d expected 0", fwd_rs_d); else n_pass++;
    advance();
    drive(0, 0, 3, 3, 0, 0, 0);
    n_checks++;
    if (fwd_rs_e !== 2'd2) $display("FAIL nearest_fwd_e: got %0d expected 2", fwd_rs_e); else n_pass++;
    advance();
  endtask

  task automatic test_reg_zero();
    idle(3);
    drive(0, 0, 3, 3, 0, 2, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({stall, fwd_rs_d, fwd_rt_d} !== 5'd0)
      $display("FAIL reg0_d: got stall=%b fwd=%0d/%0d expected 0", stall, fwd_rs_d, fwd_rt_d);
    else n_pass++;
    advance();
    drive(0, 0, 3, 3, 0, 0, 0);
    n_checks++;
    if ({fwd_rs_e, fwd_rt_e} !== 4'd0)
      $display("FAIL reg0_e: got fwd_e=%0d/%0d expected 0", fwd_rs_e, fwd_rt_e);
    else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    drive(0, 0, 3, 3, 6, 2, 0); advance();
    drive(6, 0, 0, 3, 0, 0, 0);
    n_checks++;
    if (stall !== 1'b1) $display("FAIL midrst_pre_stall: got %b expected 1", stall); else n_pass++;
    advance();
    drive(6, 0, 0, 3, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 9'd0)
      $display("FAIL midrst_async: got stall=%b fwd=%0d/%0d/%0d/%0d expected all 0",
               stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e);
    else n_pass++;
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_cnt !== 32'd0) $display("FAIL midrst_cnt: got %0d expected 0", stall_cnt);
    else n_pass++;
`endif
    rst_n = 1'b1;
    model_reset();
    advance();
  endtask

  task automatic test_random();
    logic [1:0] e_rs_d, e_rt_d, e_rs_e, e_rt_e;
    logic       e_stall;
    idle(3);
    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0));
      e_stall = m_stall();
      e_rs_d  = 2'(m_fwd_d(int'(rs_d)));
      e_rt_d  = 2'(m_fwd_d(int'(rt_d)));
      e_rs_e  = 2'(m_fwd_e(m_rs_e));
      e_rt_e  = 2'(m_fwd_e(m_rt_e));
      n_checks++;
      if (stall !== e_stall) $display("FAIL rand_stall[%0d]: got %b expected %b", n, stall, e_stall);
      else n_pass++;
      n_checks++;
      if (fwd_rs_d !== e_rs_d) $display("FAIL rand_fwd_rs_d[%0d]: got %0d expected %0d", n, fwd_rs_d, e_rs_d);
      else n_pass++;
      n_checks++;
      if (fwd_rt_d !== e_rt_d) $display("FAIL rand_fwd_rt_d[%0d]: got %0d expected %0d", n, fwd_rt_d, e_rt_d);
      else n_pass++;
      n_checks++;
      if (fwd_rs_e !== e_rs_e) $display("FAIL rand_fwd_rs_e[%0d]: got %0d expected %0d", n, fwd_rs_e, e_rs_e);
      else n_pass++;
      n_checks++;
      if (fwd_rt_e !== e_rt_e) $display("FAIL rand_fwd_rt_e[%0d]: got %0d expected %0d", n, fwd_rt_e, e_rt_e);
      else n_pass++;
`ifdef HAZARD_STATS_EN
      n_checks++;
      if (stall_cnt !== m_cnt) $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, stall_cnt, m_cnt);
      else n_pass++;
      n_checks++;
      if (stall_rs_only !== (m_hz(int'(rs_d), int'(rs_tuse_d)) & ~m_hz(int'(rt_d), int'(rt_tuse_d))))
        $display("FAIL rand_rs_only[%0d]: got %b", n, stall_rs_only);
      else n_pass++;
`endif
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_store_data();
    test_nearest_wins();
    test_reg_zero();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
